// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter
//   Round-robin arbiter with grant locking and a forced-release hold limit.
//   A requester that keeps req and lock high may hold its grant for up to
//   MAX_HOLD consecutive cycles. After that the grant is taken away and
//   timeout pulses for one cycle. When a grant ends, the ended grantee drops
//   to lowest priority for the next arbitration.
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   req        per-requester request
//   lock       per-requester grant hold; only the current grantee's bit matters
//   gnt        registered one-hot grant; all-zero when idle
//   gnt_idx    registered binary index of gnt; 0 when idle
//   gnt_valid  registered; high whenever gnt is non-zero
//   timeout    registered one-cycle pulse marking a forced release
module rr_lock_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_valid,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state_q;
  logic [IW-1:0]    ptr_q;
  logic [HW-1:0]    hcnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IW-1:0]    gnt_idx_q;
  logic             gnt_valid_q;
  logic             timeout_q;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    ptr_d;
  logic [IW:0]      scan_sum;
  logic             hold_max;
  logic             keep_gnt;
  logic             forced_rel;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Wrap-around scan starting at ptr_q. Walking from the far end back toward
  // offset 0 lets the nearest set request overwrite the others.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_sum = {1'b0, ptr_q} + (IW + 1)'(i);
      if (scan_sum >= (IW + 1)'(N_REQ)) begin
        scan_sum = scan_sum - (IW + 1)'(N_REQ);
      end
      if (req[scan_sum[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[IW-1:0];
      end
    end
  end

  // The next pointer sits one past the winner, so a new grantee drops to
  // lowest priority for the following arbitration.
  assign ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  assign hold_max   = (hcnt_q == HW'(MAX_HOLD - 1));
  assign keep_gnt   = req[gnt_idx_q] && lock[gnt_idx_q];
  assign forced_rel = keep_gnt && hold_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hcnt_q      <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q     <= GRANTED;
            gnt_q       <= onehot(win_idx);
            gnt_idx_q   <= win_idx;
            gnt_valid_q <= 1'b1;
            hcnt_q      <= '0;
            ptr_q       <= ptr_d;
          end
        end
        GRANTED: begin
          if (keep_gnt && !hold_max) begin
            hcnt_q <= hcnt_q + 1'b1;
          end else begin
            // Grant ends this edge; hand over immediately with no idle bubble.
            timeout_q <= forced_rel;
            if (win_found) begin
              gnt_q       <= onehot(win_idx);
              gnt_idx_q   <= win_idx;
              gnt_valid_q <= 1'b1;
              hcnt_q      <= '0;
              ptr_q       <= ptr_d;
            end else begin
              state_q     <= IDLE;
              gnt_q       <= '0;
              gnt_idx_q   <= '0;
              gnt_valid_q <= 1'b0;
              hcnt_q      <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/rr_lock_arbiter.md
RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 8, number of requesters (N_REQ >= 2).
REQ-002 SHALL have parameter MAX_HOLD, default 16, max consecutive cycles one locked grant may last (MAX_HOLD >= 2).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  N_REQ  per-requester request.
REQ-006 SHALL have port lock  in  N_REQ  per-requester grant-hold; meaningful only for the current grantee.
REQ-007 SHALL have port gnt  out  N_REQ  registered one-hot grant; all-zero when idle.
REQ-008 SHALL have port gnt_idx  out  $clog2(N_REQ)  registered binary index of gnt; 0 when idle.
REQ-009 SHALL have port gnt_valid  out  1  registered; high when gnt is non-zero.
REQ-010 SHALL have port timeout  out  1  registered one-cycle pulse marking a forced release.

Function
REQ-011 SHALL implement states IDLE (no grant) and GRANTED (one grant active).
REQ-012 Internal state: rotating pointer ptr (0..N_REQ-1), hold counter hcnt (0..MAX_HOLD-1), current grantee g.
REQ-013 Winner selection SHALL be the first set req bit scanning ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1 (wrap-around); no winner if req is all-zero.
REQ-014 IDLE: at each edge with a winner w, gnt<=onehot(w), gnt_idx<=w, hcnt<=0, ptr<=(w+1) mod N_REQ, go GRANTED; with no winner stay IDLE, outputs zero.
REQ-015 Request-to-grant latency SHALL be exactly one clock edge.
REQ-016 GRANTED: the grant SHALL end at the current edge if any of: !req[g]; !lock[g]; hcnt==MAX_HOLD-1.
REQ-017 GRANTED and not ending: gnt unchanged, hcnt<=hcnt+1, ptr unchanged.
REQ-018 GRANTED and ending: winner selected per REQ-013 from the current req, using ptr (already g+1), so g has lowest priority; new grant per REQ-014 in the same edge, no idle bubble.
REQ-019 Ending with no winner SHALL go IDLE with gnt=0, gnt_idx=0, gnt_valid=0.
REQ-020 Without lock, a continuously requesting set SHALL be served one cycle each in strict rotation.
REQ-021 When the end cause is solely hcnt==MAX_HOLD-1 (req[g] and lock[g] still high), timeout SHALL be 1 in the cycle after that edge, else 0.
REQ-022 If g is the sole requester at a timeout, g SHALL be re-granted back-to-back with hcnt<=0; gnt stays continuously high.
REQ-023 gnt SHALL be one-hot or zero in every cycle; gnt_valid == |gnt always.
REQ-024 Changes to lock of non-grantees SHALL have no effect.
REQ-025 Each locked grant SHALL last at most MAX_HOLD cycles; with all N_REQ requesting, any requester SHALL be granted within (N_REQ-1)*MAX_HOLD+1 cycles of asserting req.

Reset
REQ-026 rst high SHALL immediately, without waiting for clk, force gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hcnt=0, state IDLE.
REQ-027 Reset mid-grant SHALL drop the grant immediately; first edge after rst falls arbitrates from ptr=0.

Verification (N_REQ=4, MAX_HOLD=4)
REQ-028 Reset: rst=1 with req=4'b1111 -> gnt=0000, gnt_idx=0, gnt_valid=0, timeout=0; release rst -> next edge gnt=0001.
REQ-029 Rotation: req=1111, lock=0000 held -> gnt 0001,0010,0100,1000,0001 on consecutive cycles, no gaps.
REQ-030 Timeout: req=0101, lock=0001 -> gnt=0001 for 4 cycles, then gnt=0100 with timeout=1 for that one cycle, then gnt=0001 with timeout=0.
REQ-031 Sole locked requester: req=0010, lock=0010 for 12 cycles -> gnt=0010 continuously, timeout pulses in cycles 5 and 9 of the grant.
REQ-032 Early release and idle: req=1000 with lock=1000 for 2 cycles, then req=0000 -> gnt=1000 for 2 cycles, then gnt=0000, gnt_valid=0; next req=0001 -> gnt=0001 one edge later.
REQ-033 Async reset mid-grant: gnt=0100 locked, rst pulsed between edges -> gnt=0000 before next edge; after release with req=1111, first grant is 0001.
